eth_rx_frame_ctrl: RTL and testbench
====================================

Name: eth_rx_frame_ctrl

Overview:
Receive-side frame sequencer that sits directly after the RGMII DDR-to-SDR receive stage. It consumes the local-clock byte stream (rxData/rxDataValid) and performs preamble/SFD detection, MAC header extraction and destination-address filtering. It strips the 4-byte FCS through a delay line, forwards payload bytes to the book-building parser, and reports a per-frame status with good/error counters.

Parameters:
MAC_ADDR, 48'h02_00_00_00_00_01, local unicast address accepted by the filter
PROMISC, 1'b0, 1 = accept any destination address
MIN_FRAME_BYTES, 64, minimum length from dst MAC through FCS inclusive
MAX_FRAME_BYTES, 1518, maximum length from dst MAC through FCS inclusive
MAX_PREAMBLE, 7, maximum number of 0x55 bytes allowed before the SFD

Ports:
rxClkLcl  in  1  local receive clock; the single clock of the block
rst  in  1  synchronous, active-high reset
rxData  in  8  received byte
rxDataValid  in  1  byte qualifier, high for the whole frame including preamble
payloadData  out  8  payload byte (FCS excluded)
payloadValid  out  1  payloadData qualifier
hdrValid  out  1  1-cycle pulse when dstMac, srcMac and etherType are updated
dstMac  out  48  destination MAC of the current frame
srcMac  out  48  source MAC of the current frame
etherType  out  16  EtherType/length field
frameDone  out  1  1-cycle pulse, exactly once per frame
frameStatus  out  3  rx_status_t, valid while frameDone is high
goodFrameCnt  out  16  count of frames with status ST_OK, wraps
errFrameCnt  out  16  count of frames with any other status, wraps

Behaviour:
- Reset: all outputs 0; state IDLE; armed = 0. The block accepts no frame until rxDataValid is sampled low for at least one cycle (this prevents mid-frame lock-on).
- All outputs are registered. Byte index n counts from the first byte after the SFD (n = 0 is dstMac[47:40], big-endian).
- IDLE, armed, rxDataValid = 1:
  - 0x55 -> PREAMBLE with pre = 1.
  - 0xD5 -> HEADER.
  - Any other byte -> DROP with status BAD_PREAMBLE.
- PREAMBLE:
  - 0x55 -> pre++; if pre would exceed MAX_PREAMBLE -> DROP (BAD_PREAMBLE).
  - 0xD5 -> HEADER, n = 0.
  - Any other byte -> DROP (BAD_PREAMBLE).
  - rxDataValid = 0 -> END (BAD_PREAMBLE).
- HEADER (n = 0..13): shift bytes into dstMac/srcMac/etherType shadow registers.
  - At n = 5: if dst != MAC_ADDR, dst != 48'hFFFF_FFFF_FFFF and !PROMISC -> DROP (FILTERED).
  - At n = 13: copy shadows to the outputs and pulse hdrValid one cycle later -> PAYLOAD.
  - rxDataValid = 0 -> END (RUNT).
- PAYLOAD: each byte enters a 4-entry shift register. Once it is full, each new byte pushes out the oldest, which is presented on payloadData/payloadValid the next cycle.
  - rxDataValid = 0 -> END; the 4 held bytes (the FCS) are discarded and never output.
- Length: n increments on every post-SFD byte.
  - Length = n at end of frame.
  - Length < MIN_FRAME_BYTES -> RUNT.
  - If n reaches MAX_FRAME_BYTES while valid is still high -> DROP (GIANT), and forwarding stops immediately.
- DROP: ignore bytes; on rxDataValid = 0 -> END with the latched status.
- END: pulse frameDone with frameStatus; increment goodFrameCnt or errFrameCnt; clear the delay line; -> IDLE.
  - frameDone occurs exactly 1 cycle after the cycle in which rxDataValid is first sampled low.
- Runt frames that reached PAYLOAD may already have emitted payload bytes. The downstream block must discard the frame when frameStatus != ST_OK.
- rxDataValid high again in END is not possible with a legal IFG (>= 12 bytes). If it happens anyway, the block ignores it until the valid signal next goes low (armed cleared).
- Counters wrap from 16'hFFFF to 0.
- rst mid-frame: return to the reset state immediately; no frameDone for the aborted frame.

Decomposition:
- eth_pkg holds typedef enum logic [2:0] rx_status_t:
  - ST_OK = 0
  - ST_RUNT = 1
  - ST_GIANT = 2
  - ST_BAD_PREAMBLE = 3
  - ST_FILTERED = 4
- eth_pkg also holds the constants PREAMBLE_BYTE = 8'h55, SFD_BYTE = 8'hD5, ETH_HDR_BYTES = 14, ETH_FCS_BYTES = 4, and BCAST_MAC.
- One sub-module: eth_fcs_strip, the 4-deep byte delay line with flush input, data/valid in and data/valid out.

Test Plan:
- Frame 1: 7x55, D5, dst = MAC_ADDR, src = 02:11:22:33:44:55, type 0x0800, 46 payload bytes 0x00..0x2D, 4 FCS bytes.
  - hdrValid with the correct fields.
  - Exactly 46 payloadValid bytes 0x00..0x2D.
  - frameDone with ST_OK; goodFrameCnt = 1.
- Broadcast dst FF..FF with PROMISC = 0 -> ST_OK. Dst 02:00:00:00:00:99 -> ST_FILTERED with no payloadValid and no hdrValid; errFrameCnt = 1.
- Preamble 55 55 AA -> ST_BAD_PREAMBLE. Eight 0x55 bytes then D5 -> ST_BAD_PREAMBLE. Only the SFD (zero 0x55 bytes) -> ST_OK.
- 60-byte frame -> ST_RUNT. 1519-byte frame -> ST_GIANT with payloadValid stopping at n = 1518. 1518-byte frame -> ST_OK.
- Assert rst at payload byte 20 with rxDataValid still high -> outputs 0 and no frameDone. The next valid frame after an IFG -> ST_OK.
- Two back-to-back frames with a 12-cycle IFG -> two frameDone pulses, goodFrameCnt = 2, and the payload of the second frame is not corrupted by FCS bytes of the first.

Source files
------------

// File: rtl/eth_rx_frame_ctrl_pkg.sv
// Shared types and constants for the Ethernet receive frame sequencer.
package eth_pkg;

    typedef enum logic [2:0] {
        ST_OK           = 3'd0,
        ST_RUNT         = 3'd1,
        ST_GIANT        = 3'd2,
        ST_BAD_PREAMBLE = 3'd3,
        ST_FILTERED     = 3'd4
    } rx_status_t;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam int          ETH_HDR_BYTES = 14;
    localparam int          ETH_FCS_BYTES = 4;
    localparam int          ETH_MAC_BYTES = 6;
    localparam logic [47:0] BCAST_MAC     = 48'hFFFF_FFFF_FFFF;

    // Destination filter: own unicast, broadcast, or anything in promiscuous mode.
    function automatic logic mac_accept(input logic [47:0] dst,
                                        input logic [47:0] own_mac,
                                        input logic        promisc);
        return promisc || (dst == own_mac) || (dst == BCAST_MAC);
    endfunction

endpackage

// File: rtl/eth_rx_frame_ctrl_if.sv
// Byte-stream input and frame/header/payload outputs of the receive sequencer.
interface eth_rx_frame_ctrl_if;
    import eth_pkg::*;

    logic [7:0]  rxData;
    logic        rxDataValid;
    logic [7:0]  payloadData;
    logic        payloadValid;
    logic        hdrValid;
    logic [47:0] dstMac;
    logic [47:0] srcMac;
    logic [15:0] etherType;
    logic        frameDone;
    rx_status_t  frameStatus;
    logic [15:0] goodFrameCnt;
    logic [15:0] errFrameCnt;

    // master: the receive stage feeding bytes in and observing results
    modport master (
        output rxData, rxDataValid,
        input  payloadData, payloadValid, hdrValid, dstMac, srcMac, etherType,
               frameDone, frameStatus, goodFrameCnt, errFrameCnt
    );

    // slave: the sequencer itself
    modport slave (
        input  rxData, rxDataValid,
        output payloadData, payloadValid, hdrValid, dstMac, srcMac, etherType,
               frameDone, frameStatus, goodFrameCnt, errFrameCnt
    );

endinterface

// File: rtl/eth_fcs_strip.sv
// Byte delay line that withholds the last DEPTH bytes of a frame (the FCS).
// A byte leaves only when a newer one pushes it out, so the tail is never emitted.
module eth_fcs_strip
    import eth_pkg::*;
#(
    parameter int DEPTH = ETH_FCS_BYTES
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       flush_i,
    input  logic [7:0] data_i,
    input  logic       valid_i,
    output logic [7:0] data_o,
    output logic       valid_o
);
    localparam int             CW   = $clog2(DEPTH + 1);
    localparam logic [CW-1:0]  FULL = CW'(DEPTH);

    logic [DEPTH-1:0][7:0] sr_q;
    logic [CW-1:0]         cnt_q;
    logic [7:0]            data_q;
    logic                  valid_q;

    // Shift in on every push; once full, the oldest byte is registered out.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            sr_q    <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (valid_i) begin
                sr_q <= {sr_q[DEPTH-2:0], data_i};
                if (cnt_q == FULL) begin
                    data_q  <= sr_q[DEPTH-1];
                    valid_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/eth_rx_frame_ctrl.sv
// Receive frame sequencer: preamble/SFD detection, header extraction,
// destination filtering, FCS stripping, per-frame status and counters.
module eth_rx_frame_ctrl
    import eth_pkg::*;
#(
    parameter logic [47:0] MAC_ADDR        = 48'h02_00_00_00_00_01,
    parameter logic        PROMISC         = 1'b0,
    parameter int          MIN_FRAME_BYTES = 64,
    parameter int          MAX_FRAME_BYTES = 1518,
    parameter int          MAX_PREAMBLE    = 7
) (
    input logic                rxClkLcl,
    input logic                rst,
    eth_rx_frame_ctrl_if.slave bus_if
);
    localparam int NW       = $clog2(MAX_FRAME_BYTES + 1);
    localparam int PW       = $clog2(MAX_PREAMBLE + 2);
    localparam int HDR_SH_W = (ETH_HDR_BYTES - 1) * 8;

    localparam logic [NW-1:0] N_DST_LAST = NW'(ETH_MAC_BYTES - 1);
    localparam logic [NW-1:0] N_HDR_LAST = NW'(ETH_HDR_BYTES - 1);
    localparam logic [NW-1:0] N_MIN      = NW'(MIN_FRAME_BYTES);
    localparam logic [NW-1:0] N_MAX      = NW'(MAX_FRAME_BYTES);
    localparam logic [PW-1:0] PRE_MAX    = PW'(MAX_PREAMBLE);

    typedef enum logic [2:0] {
        S_IDLE, S_PREAMBLE, S_HEADER, S_PAYLOAD, S_DROP, S_END
    } state_t;

    state_t               state_q;
    logic                 armed_q;
    logic [PW-1:0]        pre_q;
    logic [NW-1:0]        n_q;
    logic [HDR_SH_W-1:0]  hdr_sh_q;
    rx_status_t           status_q;
    logic [47:0]          dstMac_q;
    logic [47:0]          srcMac_q;
    logic [15:0]          etherType_q;
    logic                 hdrValid_q;
    logic                 frameDone_q;
    rx_status_t           frameStatus_q;
    logic [15:0]          goodCnt_q;
    logic [15:0]          errCnt_q;

    logic [7:0]                 rx_data;
    logic                       rx_vld;
    logic [47:0]                dst_early_d;
    logic [ETH_HDR_BYTES*8-1:0] hdr_full_d;
    logic                       push_d;
    logic                       flush_d;
    logic [7:0]                 pay_data;
    logic                       pay_valid;

    assign rx_data = bus_if.rxData;
    assign rx_vld  = bus_if.rxDataValid;

    // Header views including the byte currently on the bus.
    assign dst_early_d = {hdr_sh_q[ETH_MAC_BYTES*8-9:0], rx_data};
    assign hdr_full_d  = {hdr_sh_q, rx_data};

    // Only post-header bytes enter the delay line; the byte that makes
    // the frame a giant is already withheld.
    assign push_d  = (state_q == S_PAYLOAD) && rx_vld && (n_q != N_MAX);
    assign flush_d = (state_q == S_END);

    // Frame sequencer with registered header/status/counter outputs.
    always_ff @(posedge rxClkLcl) begin
        if (rst) begin
            state_q       <= S_IDLE;
            armed_q       <= 1'b0;
            pre_q         <= '0;
            n_q           <= '0;
            hdr_sh_q      <= '0;
            status_q      <= ST_OK;
            dstMac_q      <= '0;
            srcMac_q      <= '0;
            etherType_q   <= '0;
            hdrValid_q    <= 1'b0;
            frameDone_q   <= 1'b0;
            frameStatus_q <= ST_OK;
            goodCnt_q     <= '0;
            errCnt_q      <= '0;
        end else begin
            hdrValid_q  <= 1'b0;
            frameDone_q <= 1'b0;
            // A low valid between frames arms the detector so we never lock on mid-frame.
            if (!rx_vld) armed_q <= 1'b1;

            case (state_q)
                S_IDLE: begin
                    if (rx_vld && armed_q) begin
                        n_q   <= '0;
                        pre_q <= '0;
                        if (rx_data == PREAMBLE_BYTE) begin
                            pre_q   <= PW'(1);
                            state_q <= S_PREAMBLE;
                        end else if (rx_data == SFD_BYTE) begin
                            state_q <= S_HEADER;
                        end else begin
                            status_q <= ST_BAD_PREAMBLE;
                            state_q  <= S_DROP;
                        end
                    end
                end

                S_PREAMBLE: begin
                    if (!rx_vld) begin
                        status_q <= ST_BAD_PREAMBLE;
                        state_q  <= S_END;
                    end else if (rx_data == PREAMBLE_BYTE) begin
                        if (pre_q == PRE_MAX) begin
                            status_q <= ST_BAD_PREAMBLE;
                            state_q  <= S_DROP;
                        end else begin
                            pre_q <= pre_q + 1'b1;
                        end
                    end else if (rx_data == SFD_BYTE) begin
                        state_q <= S_HEADER;
                    end else begin
                        status_q <= ST_BAD_PREAMBLE;
                        state_q  <= S_DROP;
                    end
                end

                S_HEADER: begin
                    if (!rx_vld) begin
                        status_q <= ST_RUNT;
                        state_q  <= S_END;
                    end else begin
                        hdr_sh_q <= {hdr_sh_q[HDR_SH_W-9:0], rx_data};
                        n_q      <= n_q + 1'b1;
                        if (n_q == N_DST_LAST && !mac_accept(dst_early_d, MAC_ADDR, PROMISC)) begin
                            status_q <= ST_FILTERED;
                            state_q  <= S_DROP;
                        end else if (n_q == N_HDR_LAST) begin
                            dstMac_q    <= hdr_full_d[111:64];
                            srcMac_q    <= hdr_full_d[63:16];
                            etherType_q <= hdr_full_d[15:0];
                            hdrValid_q  <= 1'b1;
                            state_q     <= S_PAYLOAD;
                        end
                    end
                end

                S_PAYLOAD: begin
                    if (!rx_vld) begin
                        status_q <= (n_q < N_MIN) ? ST_RUNT : ST_OK;
                        state_q  <= S_END;
                    end else if (n_q == N_MAX) begin
                        status_q <= ST_GIANT;
                        state_q  <= S_DROP;
                    end else begin
                        n_q <= n_q + 1'b1;
                    end
                end

                S_DROP: begin
                    if (!rx_vld) state_q <= S_END;
                end

                S_END: begin
                    frameDone_q   <= 1'b1;
                    frameStatus_q <= status_q;
                    if (status_q == ST_OK) goodCnt_q <= goodCnt_q + 1'b1;
                    else                   errCnt_q  <= errCnt_q + 1'b1;
                    // Valid already high again means an illegal IFG; wait for the next low.
                    if (rx_vld) armed_q <= 1'b0;
                    state_q <= S_IDLE;
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    eth_fcs_strip #(
        .DEPTH(ETH_FCS_BYTES)
    ) u_fcs_strip (
        .clk_i  (rxClkLcl),
        .rst_i  (rst),
        .flush_i(flush_d),
        .data_i (rx_data),
        .valid_i(push_d),
        .data_o (pay_data),
        .valid_o(pay_valid)
    );

    assign bus_if.payloadData  = pay_data;
    assign bus_if.payloadValid = pay_valid;
    assign bus_if.hdrValid     = hdrValid_q;
    assign bus_if.dstMac       = dstMac_q;
    assign bus_if.srcMac       = srcMac_q;
    assign bus_if.etherType    = etherType_q;
    assign bus_if.frameDone    = frameDone_q;
    assign bus_if.frameStatus  = frameStatus_q;
    assign bus_if.goodFrameCnt = goodCnt_q;
    assign bus_if.errFrameCnt  = errCnt_q;

endmodule

// File: tb/tb_eth_rx_frame_ctrl.sv
// Directed bench for the receive frame sequencer.
module tb_eth_rx_frame_ctrl;
    localparam logic [47:0] MAC  = 48'h02_00_00_00_00_01;
    localparam logic [47:0] SRC  = 48'h02_11_22_33_44_55;
    localparam logic [47:0] BAD  = 48'h02_00_00_00_00_99;
    localparam logic [47:0] BCST = 48'hFFFF_FFFF_FFFF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    eth_rx_frame_ctrl_if bus_if ();

    eth_rx_frame_ctrl dut (
        .rxClkLcl(clk),
        .rst     (rst),
        .bus_if  (bus_if)
    );

    int n_chk  = 0;
    int n_fail = 0;

    int          cyc = 0;
    int          low_cyc = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    logic [2:0]  last_status = '0;
    int          hdr_cnt = 0;
    logic [47:0] hdr_dst = '0;
    logic [47:0] hdr_src = '0;
    logic [15:0] hdr_type = '0;
    logic [7:0]  pay_q[$];
    logic [7:0]  frm[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Observe outputs on the falling edge.
    always @(negedge clk) begin
        if (bus_if.payloadValid) pay_q.push_back(bus_if.payloadData);
        if (bus_if.hdrValid) begin
            hdr_cnt++;
            hdr_dst  = bus_if.dstMac;
            hdr_src  = bus_if.srcMac;
            hdr_type = bus_if.etherType;
        end
        if (bus_if.frameDone) begin
            done_cnt++;
            done_cyc    = cyc;
            last_status = bus_if.frameStatus;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [7:0] b);
        @(posedge clk); #1;
        bus_if.rxData      = b;
        bus_if.rxDataValid = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            bus_if.rxData      = 8'h00;
            bus_if.rxDataValid = 1'b0;
        end
    endtask

    // Preamble + SFD + dst/src/type + incrementing payload + F0..F3 as FCS.
    task automatic build(input int npre, input logic [47:0] dst, input int len, input logic [7:0] seed);
        frm.delete();
        repeat (npre) frm.push_back(8'h55);
        frm.push_back(8'hD5);
        for (int i = 0; i < 6; i++) frm.push_back(dst[47-8*i -: 8]);
        for (int i = 0; i < 6; i++) frm.push_back(SRC[47-8*i -: 8]);
        frm.push_back(8'h08);
        frm.push_back(8'h00);
        for (int i = 14; i < len - 4; i++) frm.push_back(8'(int'(seed) + i - 14));
        for (int i = 0; i < 4; i++) frm.push_back(8'(8'hF0 + i));
    endtask

    task automatic send_frm();
        foreach (frm[i]) drive(frm[i]);
        @(posedge clk); #1;
        bus_if.rxData      = 8'h00;
        bus_if.rxDataValid = 1'b0;
        low_cyc = cyc;
    endtask

    task automatic wait_done(input int target);
        for (int i = 0; i < 20; i++) begin
            if (done_cnt >= target) break;
            @(posedge clk);
        end
        @(negedge clk);
    endtask

    task automatic run(input string tag, input logic [2:0] st, input int npay, input int nhdr,
                       input int good, input int err);
        int d0;
        d0 = done_cnt;
        pay_q.delete();
        hdr_cnt = 0;
        send_frm();
        wait_done(d0 + 1);
        chk({tag, "_done"}, done_cnt - d0, 1);
        chk({tag, "_lat"}, done_cyc - low_cyc, 2);
        chk({tag, "_st"}, last_status, st);
        chk({tag, "_npay"}, pay_q.size(), npay);
        chk({tag, "_nhdr"}, hdr_cnt, nhdr);
        idle(11);
        chk({tag, "_good"}, bus_if.goodFrameCnt, good);
        chk({tag, "_err"}, bus_if.errFrameCnt, err);
    endtask

    initial begin
        int d0;
        int bad;
        bus_if.rxData      = 8'h00;
        bus_if.rxDataValid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_pv", bus_if.payloadValid, 0);
        chk("rst_hv", bus_if.hdrValid, 0);
        chk("rst_fd", bus_if.frameDone, 0);
        chk("rst_dst", bus_if.dstMac, 0);
        chk("rst_good", bus_if.goodFrameCnt, 0);
        chk("rst_err", bus_if.errFrameCnt, 0);
        rst = 1'b0;
        idle(5);

        // Nominal 64-byte frame to our own address.
        build(7, MAC, 64, 8'h00);
        run("f1", 3'd0, 46, 1, 1, 0);
        chk("f1_dst", hdr_dst, MAC);
        chk("f1_src", hdr_src, SRC);
        chk("f1_type", hdr_type, 16'h0800);
        bad = 0;
        for (int k = 0; k < 46 && k < pay_q.size(); k++)
            if (pay_q[k] !== 8'(k)) bad++;
        chk("f1_paydata", bad, 0);

        build(7, BCST, 64, 8'h00);
        run("bcast", 3'd0, 46, 1, 2, 0);

        build(7, BAD, 64, 8'h00);
        run("filt", 3'd4, 0, 0, 2, 1);

        // 55 55 AA: SFD slot replaced by a junk byte.
        build(2, MAC, 64, 8'h00);
        frm[2] = 8'hAA;
        run("pre_aa", 3'd3, 0, 0, 2, 2);

        build(8, MAC, 64, 8'h00);
        run("pre8", 3'd3, 0, 0, 2, 3);

        build(0, MAC, 64, 8'h00);
        run("pre0", 3'd0, 46, 1, 3, 3);

        build(7, MAC, 60, 8'h00);
        run("runt", 3'd1, 42, 1, 3, 4);

        build(7, MAC, 1519, 8'h00);
        run("giant", 3'd2, 1500, 1, 3, 5);
        chk("giant_last", (pay_q.size() > 0) ? pay_q[pay_q.size()-1] : 8'h00, 8'hDB);

        build(7, MAC, 1518, 8'h00);
        run("max", 3'd0, 1500, 1, 4, 5);

        // Reset at payload byte 20 while the frame is still streaming.
        build(7, MAC, 64, 8'h00);
        d0 = done_cnt;
        for (int i = 0; i < 42; i++) drive(frm[i]);
        drive(frm[42]);
        rst = 1'b1;
        drive(frm[43]);
        drive(frm[44]);
        rst = 1'b0;
        @(negedge clk);
        chk("mrst_good", bus_if.goodFrameCnt, 0);
        chk("mrst_err", bus_if.errFrameCnt, 0);
        chk("mrst_dst", bus_if.dstMac, 0);
        chk("mrst_pv", bus_if.payloadValid, 0);
        pay_q.delete();
        hdr_cnt = 0;
        for (int i = 45; i < frm.size(); i++) drive(frm[i]);
        idle(12);
        chk("mrst_nodone", done_cnt - d0, 0);
        chk("mrst_npay", pay_q.size(), 0);
        chk("mrst_nhdr", hdr_cnt, 0);

        build(7, MAC, 64, 8'h00);
        run("post_rst", 3'd0, 46, 1, 1, 0);

        // Back-to-back frames with a 12-cycle gap.
        d0 = done_cnt;
        pay_q.delete();
        build(7, MAC, 64, 8'h00);
        send_frm();
        idle(11);
        build(7, MAC, 64, 8'h80);
        send_frm();
        wait_done(d0 + 2);
        chk("b2b_done", done_cnt - d0, 2);
        chk("b2b_st", last_status, 0);
        chk("b2b_npay", pay_q.size(), 92);
        bad = 0;
        for (int k = 0; k < 46 && 46 + k < pay_q.size(); k++)
            if (pay_q[46+k] !== 8'(8'h80 + k)) bad++;
        chk("b2b_paydata", bad, 0);
        idle(11);
        chk("b2b_good", bus_if.goodFrameCnt, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
